// File: rtl/accel_pkg.sv
// Shared constants and types for the accelerometer sample path:
// axis slot codes, the assembler state encoding and the sample width.
package accel_pkg;

  localparam int unsigned SAMPLE_W = 48;

  localparam logic [1:0] SLOT_X = 2'd2;
  localparam logic [1:0] SLOT_Y = 2'd1;
  localparam logic [1:0] SLOT_Z = 2'd0;

  typedef enum logic [1:0] {
    WAIT_X = 2'd0,
    WAIT_Y = 2'd1,
    WAIT_Z = 2'd2
  } asm_state_e;

  function automatic logic [15:0] swap16(input logic [15:0] d);
    return {d[7:0], d[15:8]};
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through sample FIFO. The head entry is always visible on rdata.
// A push that arrives while the FIFO is full is dropped and flagged, unless a pop happens in the same cycle.
module sample_fifo
  import accel_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned WIDTH  = SAMPLE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [WIDTH-1:0]  rdata,
  output logic [ADDR_W:0]   level,
  output logic              drop
);

  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              pop;
  logic              accept;

  assign full     = (count == FULL_LEVEL);
  assign rd_valid = (count != '0);
  assign pop      = rd_valid & rd_ready;
  // While full, a simultaneous pop frees the slot, so the push is still accepted.
  assign accept   = push & (~full | pop);
  assign drop     = push & full & ~pop;
  assign rdata    = mem[rd_ptr];
  assign level    = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/accel_sample_fifo.sv
// Captures X/Y/Z half-words from the SPI master read path, byte-swaps them and assembles 48-bit samples.
// Complete samples are buffered in a show-ahead FIFO that has sticky overflow and framing-error flags.
module accel_sample_fifo
  import accel_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_W     = 4,
  parameter bit          SWAP_BYTES = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [15:0]       miso_data,
  input  logic [1:0]        byte_count,
  input  logic              cs,
  input  logic              rd_ready,
  input  logic              clr_flags,
  output logic              rd_valid,
  output logic [15:0]       rd_x,
  output logic [15:0]       rd_y,
  output logic [15:0]       rd_z,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              frame_err
);

  asm_state_e state_q, state_d;

  logic        load_q;
  logic        cs_q;
  logic        cap_pend;
  logic [1:0]  slot_q;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic [15:0] cap_data;
  logic        cs_rise;
  logic        push;
  logic        fe_set;
  logic        drop;
  logic [SAMPLE_W-1:0] head;

  assign cap_data = SWAP_BYTES ? swap16(miso_data) : miso_data;
  assign cs_rise  = cs & ~cs_q;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    push    = 1'b0;
    fe_set  = 1'b0;
    if (cap_pend) begin
      case (state_q)
        WAIT_X: begin
          if (slot_q == SLOT_X) begin
            x_d     = cap_data;
            state_d = WAIT_Y;
          end else begin
            fe_set  = 1'b1;
          end
        end
        WAIT_Y: begin
          if (slot_q == SLOT_Y) begin
            y_d     = cap_data;
            state_d = WAIT_Z;
          end else if (slot_q == SLOT_X) begin
            fe_set  = 1'b1;
            x_d     = cap_data;
          end else begin
            fe_set  = 1'b1;
            state_d = WAIT_X;
          end
        end
        WAIT_Z: begin
          if (slot_q == SLOT_Z) begin
            push    = 1'b1;
            state_d = WAIT_X;
          end else if (slot_q == SLOT_X) begin
            fe_set  = 1'b1;
            x_d     = cap_data;
            state_d = WAIT_Y;
          end else begin
            fe_set  = 1'b1;
            state_d = WAIT_X;
          end
        end
        default: state_d = WAIT_X;
      endcase
    end
    // The CS check uses the post-capture state, so a CS rise on the Z capture cycle is not an error.
    if (cs_rise && state_d != WAIT_X) begin
      state_d = WAIT_X;
      fe_set  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_q    <= 1'b0;
      cs_q      <= 1'b1;
      cap_pend  <= 1'b0;
      slot_q    <= '0;
      state_q   <= WAIT_X;
      x_q       <= '0;
      y_q       <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      load_q    <= load;
      cs_q      <= cs;
      if (load && !load_q) begin
        slot_q   <= byte_count;
        cap_pend <= 1'b1;
      end else begin
        cap_pend <= 1'b0;
      end
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      overflow  <= drop   | (overflow  & ~clr_flags);
      frame_err <= fe_set | (frame_err & ~clr_flags);
    end
  end

  sample_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (SAMPLE_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .wdata    ({cap_data, y_q, x_q}),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rdata    (head),
    .level    (level),
    .drop     (drop)
  );

  assign {rd_z, rd_y, rd_x} = head;

endmodule

// File: tb/tb_accel_sample_fifo.sv
// Bench for accel_sample_fifo. A frame-level model (queue of samples plus the count of
// axes collected so far) predicts the FIFO contents, level and sticky flags.
module tb_accel_sample_fifo;

  localparam int DEPTH = 16;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] miso_data;
  logic [1:0]  byte_count;
  logic        cs;
  logic        rd_ready;
  logic        clr_flags;
  logic        rd_valid;
  logic [15:0] rd_x, rd_y, rd_z;
  logic [4:0]  level;
  logic        overflow;
  logic        frame_err;

  accel_sample_fifo #(
    .DEPTH      (16),
    .ADDR_W     (4),
    .SWAP_BYTES (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .miso_data  (miso_data),
    .byte_count (byte_count),
    .cs         (cs),
    .rd_ready   (rd_ready),
    .clr_flags  (clr_flags),
    .rd_valid   (rd_valid),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .rd_z       (rd_z),
    .level      (level),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: queued samples {z,y,x}, the number of axes collected (0..2), and the flags.
  logic [47:0] q[$];
  int          have;
  logic [15:0] px, py;
  bit          m_ovf, m_fe;

  function automatic logic [15:0] sw(input logic [15:0] d);
    return {d[7:0], d[15:8]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_capture(input logic [1:0] slot, input logic [15:0] v);
    if (have == 0) begin
      if (slot == 2'd2) begin px = v; have = 1; end
      else m_fe = 1;
    end else if (have == 1) begin
      if (slot == 2'd1) begin py = v; have = 2; end
      else if (slot == 2'd2) begin m_fe = 1; px = v; end
      else begin m_fe = 1; have = 0; end
    end else begin
      if (slot == 2'd0) begin
        if (q.size() < DEPTH) q.push_back({v, py, px});
        else m_ovf = 1;
        have = 0;
      end else if (slot == 2'd2) begin m_fe = 1; px = v; have = 1; end
      else begin m_fe = 1; have = 0; end
    end
  endtask

  // Load held `hold` cycles; byte_count only meaningful at the rise, data only in the 2nd cycle.
  task automatic send_word(input logic [1:0] slot, input logic [15:0] data,
                           input int hold, input bit pop_on_cap);
    for (int i = 0; i < hold; i++) begin
      load       = 1'b1;
      byte_count = (i == 0) ? slot : 2'($urandom);
      miso_data  = (i == 1) ? data : 16'($urandom);
      rd_ready   = (i == 1) && pop_on_cap;
      tick();
    end
    load     = 1'b0;
    rd_ready = 1'b0;
    tick();
    if (pop_on_cap && q.size() > 0) void'(q.pop_front());
    model_capture(slot, sw(data));
  endtask

  task automatic send_frame(input bit pop_on_z);
    send_word(2'd2, 16'($urandom), $urandom_range(2, 4), 1'b0);
    send_word(2'd1, 16'($urandom), $urandom_range(2, 4), 1'b0);
    send_word(2'd0, 16'($urandom), $urandom_range(2, 4), pop_on_z);
  endtask

  task automatic pop_one();
    rd_ready = 1'b1;
    if (q.size() > 0) void'(q.pop_front());
    tick();
    rd_ready = 1'b0;
  endtask

  task automatic cs_pulse();
    cs = 1'b1;
    tick();
    cs = 1'b0;
    tick();
    if (have != 0) begin m_fe = 1; have = 0; end
  endtask

  task automatic clr_pulse();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    m_ovf = 0;
    m_fe  = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    q.delete(); have = 0; m_ovf = 0; m_fe = 0;
    checks++;
    if ({rd_valid, level} !== 6'd0) begin
      failures++;
      $display("FAIL reset_fifo: rd_valid/level=%b/%0d expected 0/0", rd_valid, level);
    end
    checks++;
    if ({overflow, frame_err} !== 2'b00) begin
      failures++;
      $display("FAIL reset_flags: ovf/fe=%b%b expected 00", overflow, frame_err);
    end
  endtask

  task automatic test_capture();
    send_word(2'd2, 16'h3412, 2, 1'b0);
    send_word(2'd1, 16'h7856, 2, 1'b0);
    load = 1'b1; byte_count = 2'd0; miso_data = 16'($urandom);
    tick();
    checks++;
    if (level !== 5'd0) begin
      failures++;
      $display("FAIL capture_early: level=%0d expected 0 before Z capture cycle", level);
    end
    byte_count = 2'($urandom); miso_data = 16'hBC9A;
    tick();
    model_capture(2'd0, sw(16'hBC9A));
    checks++;
    if ({rd_valid, rd_x, rd_y, rd_z, level} !== {1'b1, 16'h1234, 16'h5678, 16'h9ABC, 5'd1}) begin
      failures++;
      $display("FAIL capture_sample: v=%b x=%h y=%h z=%h lvl=%0d expected 1 1234 5678 9abc 1",
               rd_valid, rd_x, rd_y, rd_z, level);
    end
    load = 1'b0;
    tick();
    pop_one();
    checks++;
    if ({rd_valid, level} !== 6'd0) begin
      failures++;
      $display("FAIL capture_pop: rd_valid/level=%b/%0d expected 0/0", rd_valid, level);
    end
  endtask

  task automatic test_order_errors();
    send_word(2'd2, 16'($urandom), 4, 1'b0);
    send_word(2'd1, 16'($urandom), 3, 1'b0);
    send_word(2'd0, 16'($urandom), 4, 1'b0);
    checks++;
    if ({level, frame_err, rd_z, rd_y, rd_x} !== {5'(q.size()), m_fe, q[0]}) begin
      failures++;
      $display("FAIL long_load: lvl=%0d fe=%b head=%h expected %0d %b %h",
               level, frame_err, {rd_z, rd_y, rd_x}, q.size(), m_fe, q[0]);
    end
    send_word(2'd2, 16'($urandom), 2, 1'b0);
    send_word(2'd0, 16'($urandom), 2, 1'b0);
    checks++;
    if ({level, frame_err} !== {5'd1, 1'b1}) begin
      failures++;
      $display("FAIL order_err: lvl=%0d fe=%b expected 1 1", level, frame_err);
    end
    send_frame(1'b0);
    checks++;
    if (level !== 5'd2) begin
      failures++;
      $display("FAIL order_recover: lvl=%0d expected 2", level);
    end
    while (q.size() > 0) begin
      checks++;
      if ({rd_valid, rd_z, rd_y, rd_x} !== {1'b1, q[0]}) begin
        failures++;
        $display("FAIL order_drain: v=%b head=%h expected 1 %h", rd_valid, {rd_z, rd_y, rd_x}, q[0]);
      end
      pop_one();
    end
  endtask

  task automatic test_partial();
    clr_pulse();
    send_word(2'd2, 16'($urandom), 2, 1'b0);
    send_word(2'd1, 16'($urandom), 2, 1'b0);
    cs_pulse();
    checks++;
    if ({frame_err, level} !== {1'b1, 5'd0}) begin
      failures++;
      $display("FAIL partial_cs: fe=%b lvl=%0d expected 1 0", frame_err, level);
    end
    clr_pulse();
    send_frame(1'b0);
    checks++;
    if ({frame_err, level, rd_z, rd_y, rd_x} !== {1'b0, 5'd1, q[0]}) begin
      failures++;
      $display("FAIL partial_next: fe=%b lvl=%0d head=%h expected 0 1 %h",
               frame_err, level, {rd_z, rd_y, rd_x}, q[0]);
    end
  endtask

  task automatic test_overflow();
    logic [47:0] first;
    while (q.size() > 0) pop_one();
    clr_pulse();
    for (int i = 0; i < 17; i++) send_frame(1'b0);
    first = q[0];
    checks++;
    if ({level, overflow, rd_z, rd_y, rd_x} !== {5'd16, 1'b1, first}) begin
      failures++;
      $display("FAIL overflow: lvl=%0d ovf=%b head=%h expected 16 1 %h",
               level, overflow, {rd_z, rd_y, rd_x}, first);
    end
    pop_one();
    checks++;
    if (level !== 5'd15) begin
      failures++;
      $display("FAIL overflow_pop: lvl=%0d expected 15", level);
    end
  endtask

  task automatic test_full_push_pop();
    clr_pulse();
    send_frame(1'b0);
    checks++;
    if ({level, overflow} !== {5'd16, 1'b0}) begin
      failures++;
      $display("FAIL refill: lvl=%0d ovf=%b expected 16 0", level, overflow);
    end
    send_frame(1'b1);
    checks++;
    if ({level, overflow} !== {5'd16, 1'b0}) begin
      failures++;
      $display("FAIL full_push_pop: lvl=%0d ovf=%b expected 16 0", level, overflow);
    end
    while (q.size() > 0) begin
      checks++;
      if ({rd_valid, rd_z, rd_y, rd_x} !== {1'b1, q[0]}) begin
        failures++;
        $display("FAIL full_drain: v=%b head=%h expected 1 %h", rd_valid, {rd_z, rd_y, rd_x}, q[0]);
      end
      pop_one();
    end
    rd_ready = 1'b1;
    tick();
    tick();
    rd_ready = 1'b0;
    checks++;
    if ({rd_valid, level} !== 6'd0) begin
      failures++;
      $display("FAIL empty_pop: v=%b lvl=%0d expected 0 0", rd_valid, level);
    end
  endtask

  task automatic test_clear_reset();
    send_word(2'd0, 16'($urandom), 2, 1'b0);
    checks++;
    if (frame_err !== 1'b1) begin
      failures++;
      $display("FAIL fe_set: fe=%b expected 1", frame_err);
    end
    clr_pulse();
    checks++;
    if ({overflow, frame_err} !== 2'b00) begin
      failures++;
      $display("FAIL clr: ovf/fe=%b%b expected 00", overflow, frame_err);
    end
    send_word(2'd2, 16'($urandom), 2, 1'b0);
    cs = 1'b1; clr_flags = 1'b1;
    tick();
    cs = 1'b0; clr_flags = 1'b0;
    tick();
    m_ovf = 0; m_fe = 1; have = 0;
    checks++;
    if (frame_err !== 1'b1) begin
      failures++;
      $display("FAIL set_wins: fe=%b expected 1", frame_err);
    end
    clr_pulse();
    for (int i = 0; i < 5; i++) send_frame(1'b0);
    send_word(2'd2, 16'($urandom), 2, 1'b0);
    send_word(2'd1, 16'($urandom), 2, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    q.delete(); have = 0; m_ovf = 0; m_fe = 0;
    checks++;
    if ({rd_valid, level, overflow, frame_err} !== 8'd0) begin
      failures++;
      $display("FAIL mid_reset: v=%b lvl=%0d ovf=%b fe=%b expected all 0",
               rd_valid, level, overflow, frame_err);
    end
    send_frame(1'b0);
    checks++;
    if ({rd_valid, level, frame_err, rd_z, rd_y, rd_x} !== {1'b1, 5'd1, 1'b0, q[0]}) begin
      failures++;
      $display("FAIL post_reset: v=%b lvl=%0d fe=%b head=%h expected 1 1 0 %h",
               rd_valid, level, frame_err, {rd_z, rd_y, rd_x}, q[0]);
    end
  endtask

  task automatic test_random();
    logic [1:0] slot;
    logic [1:0] exp_slot;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 19) == 0) cs_pulse();
      else if ($urandom_range(0, 19) == 0) clr_pulse();
      else begin
        exp_slot = (have == 0) ? 2'd2 : (have == 1) ? 2'd1 : 2'd0;
        slot = ($urandom_range(0, 9) < 8) ? exp_slot : 2'($urandom_range(0, 2));
        send_word(slot, 16'($urandom), $urandom_range(2, 4), ($urandom_range(0, 3) == 0));
      end
      checks++;
      if ({rd_valid, level, overflow, frame_err} !== {q.size() > 0, 5'(q.size()), m_ovf, m_fe}) begin
        failures++;
        $display("FAIL rand_status[%0d]: v=%b lvl=%0d ovf=%b fe=%b expected %b %0d %b %b",
                 n, rd_valid, level, overflow, frame_err, q.size() > 0, q.size(), m_ovf, m_fe);
      end
      if (q.size() > 0) begin
        checks++;
        if ({rd_z, rd_y, rd_x} !== q[0]) begin
          failures++;
          $display("FAIL rand_head[%0d]: head=%h expected %h", n, {rd_z, rd_y, rd_x}, q[0]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; miso_data = '0; byte_count = '0;
    cs = 1'b0; rd_ready = 1'b0; clr_flags = 1'b0;
    have = 0; px = '0; py = '0; m_ovf = 0; m_fe = 0;
    test_reset();
    test_capture();
    test_order_errors();
    test_partial();
    test_overflow();
    test_full_push_pop();
    test_clear_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
